alu_mul_sequencer: RTL and testbench

//  Multi-cycle 8x8 -> 16-bit unsigned multiplier built by sequencing the shared 8-bit Alu.

---
 rtl/alu_mul_sequencer_pkg.sv | 23 ++
 rtl/alu_mul_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: shared Alu op codes, flag bit positions and sequencer state encoding.
package alu_mul_sequencer_pkg;

    localparam logic [6:0] ALU_OP_NOP = 7'b0000000;
    localparam logic [6:0] ALU_OP_ADD = 7'b0000001;
    localparam logic [6:0] ALU_OP_SUB = 7'b0000010;
    localparam logic [6:0] ALU_OP_AND = 7'b0000100;
    localparam logic [6:0] ALU_OP_OR  = 7'b0001000;
    localparam logic [6:0] ALU_OP_XOR = 7'b0010000;
    localparam logic [6:0] ALU_OP_SHL = 7'b0100000;
    localparam logic [6:0] ALU_OP_SHR = 7'b1000000;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 8x8 -> 16-bit shift-add multiplier that borrows the shared Alu for each add.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  mcand,
    input  logic [7:0]  mplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        pzero,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_fi,
    output logic [6:0]  alu_op,
    input  logic [7:0]  alu_d,
    input  logic [7:0]  alu_fo
);

    seq_state_e  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  mc_q, mc_d;
    logic        c_q, c_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        pzero_q, pzero_d;
    logic        done_q, done_d;
    logic        unused_fo;

    assign unused_fo = ^alu_fo[7:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mc_q      <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            pzero_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mc_q      <= mc_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            pzero_q   <= pzero_d;
            done_q    <= done_d;
        end
    end

    // With SKIP_ZERO the ADD cycle is bypassed whenever the next multiplier bit is 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (SKIP_ZERO && !mplier[0]) ? ST_SHIFT : ST_ADD;
            ST_ADD:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = (cnt_q == 3'd7) ? ST_DONE :
                                (SKIP_ZERO && !lo_q[1]) ? ST_SHIFT : ST_ADD;
            default:  state_d = ST_IDLE;
        endcase
    end

    // {c,hi,lo} forms the 17-bit running product; the Alu carry lands in c before the shift.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mc_d      = mc_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        pzero_d   = pzero_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hi_d  = '0;
                    lo_d  = mplier;
                    mc_d  = mcand;
                    c_d   = 1'b0;
                    cnt_d = '0;
                end
            end
            ST_ADD: begin
                hi_d = alu_d;
                c_d  = alu_fo[FLAG_CARRY];
            end
            ST_SHIFT: begin
                hi_d  = {c_q, hi_q[7:1]};
                lo_d  = {hi_q[0], lo_q[7:1]};
                c_d   = 1'b0;
                cnt_d = cnt_q + 3'd1;
            end
            default: begin
                product_d = {hi_q, lo_q};
                pzero_d   = ~|{hi_q, lo_q};
                done_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        alu_op = (state_q == ST_ADD) ? ALU_OP_ADD : ALU_OP_NOP;
        alu_a  = (state_q == ST_ADD) ? hi_q : 8'h00;
        alu_b  = (state_q == ST_ADD && lo_q[0]) ? mc_q : 8'h00;
        alu_fi = 8'h00;
        busy   = (state_q != ST_IDLE);
    end

    assign done    = done_q;
    assign product = product_q;
    assign pzero   = pzero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench running SKIP_ZERO=0 and SKIP_ZERO=1 sequencers side by side on shared stimulus.
module tb_alu_mul_sequencer;

    typedef struct {
        logic [15:0] prod;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  mcand = '0;
    logic [7:0]  mplier = '0;
    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] product_w [2];
    logic        pzero_w [2];
    logic [7:0]  alu_a_w [2];
    logic [7:0]  alu_b_w [2];
    logic [7:0]  alu_fi_w [2];
    logic [6:0]  alu_op_w [2];
    logic [7:0]  alu_d_w [2];
    logic [7:0]  alu_fo_w [2];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_at [2] = '{0, 0};
    int          bz_lo [2] = '{1, 1};
    int          bz_hi [2] = '{0, 0};
    logic [15:0] last_prod [2] = '{16'h0, 16'h0};
    exp_t        sb [2][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [8:0] sum;
        alu_mul_sequencer #(.SKIP_ZERO(g == 1)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .mcand   (mcand),
            .mplier  (mplier),
            .busy    (busy_w[g]),
            .done    (done_w[g]),
            .product (product_w[g]),
            .pzero   (pzero_w[g]),
            .alu_a   (alu_a_w[g]),
            .alu_b   (alu_b_w[g]),
            .alu_fi  (alu_fi_w[g]),
            .alu_op  (alu_op_w[g]),
            .alu_d   (alu_d_w[g]),
            .alu_fo  (alu_fo_w[g])
        );
        // Behavioural Alu: only ADD is needed here, other ops hold zero.
        assign sum         = {1'b0, alu_a_w[g]} + {1'b0, alu_b_w[g]} + {8'h00, alu_fi_w[g][0]};
        assign alu_d_w[g]  = (alu_op_w[g] == 7'b0000001) ? sum[7:0] : 8'h00;
        assign alu_fo_w[g] = (alu_op_w[g] == 7'b0000001) ? {7'b0, sum[8]} : 8'h00;
    end

    task automatic chk(input string name, input int lane, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane=%0d cyc=%0d got=%h expected=%h", name, lane, cyc, act, exp);
        end
    endtask

    // Reference model on rising edges, checker on falling edges; one process owns the scoreboard.
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(posedge clk or negedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    sb[i].delete();
                    free_at[i] = 0;
                    bz_lo[i] = 1;
                    bz_hi[i] = 0;
                    last_prod[i] = 16'h0;
                end
            end else if (clk) begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    if (start && cyc >= free_at[i]) begin
                        lat = (i == 1) ? 9 + $countones(mplier) : 17;
                        e.prod = 16'(mcand) * 16'(mplier);
                        e.at = cyc + lat;
                        sb[i].push_back(e);
                        bz_lo[i] = cyc;
                        bz_hi[i] = cyc + lat - 1;
                        free_at[i] = cyc + lat + 1;
                    end
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    chk("busy", i, {15'b0, busy_w[i]}, {15'b0, cyc >= bz_lo[i] && cyc <= bz_hi[i]});
                    chk("alu_fi", i, {8'b0, alu_fi_w[i]}, 16'h0);
                    if (!(cyc >= bz_lo[i] && cyc <= bz_hi[i])) begin
                        chk("idle_alu_op", i, {9'b0, alu_op_w[i]}, 16'h0);
                        chk("idle_alu_ab", i, {alu_a_w[i], alu_b_w[i]}, 16'h0);
                    end
                    if (done_w[i]) begin
                        if (sb[i].size() == 0) begin
                            chk("spurious_done", i, 16'h1, 16'h0);
                        end else begin
                            e = sb[i].pop_front();
                            chk("latency", i, 16'(cyc), 16'(e.at));
                            chk("product", i, product_w[i], e.prod);
                            chk("pzero", i, {15'b0, pzero_w[i]}, {15'b0, e.prod == 16'h0});
                            last_prod[i] = e.prod;
                        end
                    end else begin
                        chk("product_hold", i, product_w[i], last_prod[i]);
                        chk("pzero_hold", i, {15'b0, pzero_w[i]}, {15'b0, last_prod[i] == 16'h0});
                        if (sb[i].size() > 0 && sb[i][0].at <= cyc) begin
                            chk("missing_done", i, 16'h0, 16'h1);
                            void'(sb[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        mcand = a;
        mplier = b;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (sb[0].size() != 0 || sb[1].size() != 0); t++) tick();
        tick();
    endtask

    task automatic chk_reset_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            chk({name, "_busy"}, i, {15'b0, busy_w[i]}, 16'h0);
            chk({name, "_done"}, i, {15'b0, done_w[i]}, 16'h0);
            chk({name, "_product"}, i, product_w[i], 16'h0);
            chk({name, "_pzero"}, i, {15'b0, pzero_w[i]}, 16'h1);
            chk({name, "_alu"}, i, {alu_a_w[i], alu_b_w[i]}, 16'h0);
            chk({name, "_alu_op"}, i, {9'b0, alu_op_w[i]}, 16'h0);
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        issue(8'd13, 8'd11);
        drain();
        chk("direct_13x11", 0, product_w[0], 16'h008F);
        issue(8'hFF, 8'hFF);
        drain();
        chk("direct_ffxff", 0, product_w[0], 16'hFE01);
        issue(8'h5A, 8'h00);
        drain();
        chk("direct_zero_pzero", 1, {15'b0, pzero_w[1]}, 16'h1);

        issue(8'd9, 8'hB7);
        tick();
        issue(8'd77, 8'd33);
        repeat (4) tick();
        issue(8'd99, 8'd66);
        drain();
        chk("ignored_start", 0, product_w[0], 16'd9 * 16'hB7);

        issue(8'd200, 8'd150);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("no_done_after_reset", 0, product_w[0], 16'h0);
        issue(8'd21, 8'd19);
        drain();

        start = 1'b1;
        mcand = 8'd2;
        mplier = 8'd7;
        tick();
        mcand = 8'd3;
        mplier = 8'd5;
        repeat (18) tick();
        start = 1'b0;
        drain();
        chk("back_to_back", 0, product_w[0], 16'h000F);

        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (n % 8 == 0) b = 8'h00;
            if (n % 8 == 1) a = 8'hFF;
            issue(a, b);
            repeat ($urandom_range(0, 20)) tick();
        end
        drain();
        for (int i = 0; i < 2; i++) chk("scoreboard_empty", i, 16'(sb[i].size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
